pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers, such as the ID/EX register.
- Carries a WIDTH-bit payload between two pipeline stages using a valid/ready handshake instead of a global load enable.
- A 2-entry skid buffer keeps full throughput while keeping in_ready registered, so backpressure does not ripple combinationally through the pipeline.
- A synchronous flush squashes in-flight contents on branch mispredict or exception.

Parameters:
- WIDTH, 32: payload width in bits; packed control word plus data fields; legal range 1 to 1024.
- CLEAR_ON_FLUSH, 1: 1 = data registers zeroed on flush; 0 = data registers hold their value on flush (only valids are cleared).
- CNT_W, 32: width of the stall counter; used only when the optional feature is compiled in.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream has a payload on in_data.
- in_ready  output  1  stage can accept a payload; driven directly from a register.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid payload.
- out_ready  input  1  downstream accepts the payload this cycle.
- out_data  output  WIDTH  payload presented downstream.
- occupancy  output  2  entries held: 0, 1 or 2.
- stall_cycles  output  CNT_W  present only with PIPE_STAGE_SKID_PERF_EN.

Behaviour:
- Storage: main entry (main_valid, main_data) and skid entry (skid_valid, skid_data).
  - out_valid = main_valid; out_data = main_data.
  - in_ready = registered copy of !skid_valid.
  - occupancy = main_valid + skid_valid.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_valid and out_valid never depend combinationally on ready.
  - Upstream must hold in_data stable while in_valid && !in_ready.
- Reset (rst=0, asynchronous): main_valid=0, skid_valid=0, main_data=0, skid_data=0, in_ready=1, occupancy=0, stall_cycles=0.
  - Takes effect immediately, including mid-transfer; no partial state survives.
  - First update after deassertion is on the next rising edge.
- State machine, states EMPTY / ONE / TWO (no flush):
  - EMPTY, in_valid=1: main <= in_data; go to ONE.
  - EMPTY, in_valid=0: stay EMPTY.
  - ONE, in xfer and out xfer: main <= in_data; stay ONE (full rate, 1 payload/cycle).
  - ONE, out xfer only: go to EMPTY.
  - ONE, in xfer only: skid <= in_data; in_ready <= 0; go to TWO.
  - ONE, neither: hold.
  - TWO (in_ready=0), out_ready=1: main <= skid_data; skid_valid <= 0; in_ready <= 1; go to ONE.
  - TWO, out_ready=0: hold all state.
- Latency: exactly 1 cycle from input transfer to out_valid when the stage was EMPTY or draining.
- Ordering: strict FIFO; no payload is dropped or duplicated outside flush.
- Flush (highest priority after reset):
  - Next state is EMPTY; main_valid=0, skid_valid=0, in_ready=1.
  - Any input transfer in the flush cycle is discarded.
  - An output transfer in the flush cycle still completes downstream; the flush only clears state for the next cycle.
  - Data registers go to 0 if CLEAR_ON_FLUSH=1, otherwise they hold.
- Boundary cases:
  - TWO with out_ready=1 and in_valid=1: input is not accepted because in_ready=0.
  - EMPTY with out_ready=1: no effect.
  - Flush while in TWO: both entries are dropped.

Optional Feature:
- Macro: PIPE_STAGE_SKID_PERF_EN.
- Defined:
  - stall_cycles port exists.
  - Increments by 1 on every cycle with out_valid && !out_ready; it counts the stall cycle even if flush is asserted that same cycle.
  - Saturates at all-ones; does not wrap.
  - Cleared only by reset.
- Undefined: port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: rst=0 for 3 cycles with random inputs, then release.
  - During reset: out_valid=0, in_ready=1, occupancy=0, out_data=0.
- Streaming: out_ready=1, in_valid=1 with data 0x1,0x2,...,0x10 on consecutive cycles.
  - out_data shows 0x1..0x10 one cycle later, back to back; occupancy stays 1; in_ready stays 1.
- Backpressure: stream 0xA,0xB,0xC with out_ready=0 from the cycle 0xA appears at the output.
  - 0xB goes to skid; in_ready=0; occupancy=2; 0xC is held upstream.
  - Raise out_ready: output order is 0xA,0xB,0xC with no loss.
- Flush: hold state TWO (0x55 main, 0x66 skid), assert flush with in_valid=1, in_data=0x77.
  - Next cycle: out_valid=0, occupancy=0, in_ready=1, and 0x77 never appears.
  - out_data=0 with CLEAR_ON_FLUSH=1; out_data=0x55 with CLEAR_ON_FLUSH=0.
- Async reset mid-operation: drop rst between clock edges while in TWO.
  - Outputs clear immediately, without waiting for a clock edge; normal acceptance resumes on the first edge after release.
- Perf counter (macro defined, CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles.
  - stall_cycles reaches 15 and stays at 15.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer that keeps in_ready registered.
// Optional stall counter is compiled in with `define PIPE_STAGE_SKID_PERF_EN.
module pipe_stage_skid #(
    parameter int unsigned WIDTH          = 32,
    parameter bit          CLEAR_ON_FLUSH = 1'b1,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef PIPE_STAGE_SKID_PERF_EN
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cycles
`else
    output logic [1:0]       occupancy
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   main_data_reg, main_data_next;
    logic [WIDTH-1:0]   skid_data_reg, skid_data_next;
    logic               in_ready_reg, in_ready_next;
    logic               main_valid, skid_valid;
    logic               in_xfer, out_xfer;

    assign main_valid = (state_reg != EMPTY);
    assign skid_valid = (state_reg == TWO);
    assign in_xfer    = in_valid && in_ready_reg;
    assign out_xfer   = main_valid && out_ready;

    assign in_ready   = in_ready_reg;
    assign out_valid  = main_valid;
    assign out_data   = main_data_reg;
    assign occupancy  = {1'b0, main_valid} + {1'b0, skid_valid};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= EMPTY;
            main_data_reg <= '0;
            skid_data_reg <= '0;
            in_ready_reg  <= 1'b1;
        end else begin
            state_reg     <= state_next;
            main_data_reg <= main_data_next;
            skid_data_reg <= skid_data_next;
            in_ready_reg  <= in_ready_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        main_data_next = main_data_reg;
        skid_data_next = skid_data_reg;
        in_ready_next  = in_ready_reg;

        if (flush) begin
            // An output transfer this cycle has already been seen downstream; only next-cycle state is squashed.
            state_next    = EMPTY;
            in_ready_next = 1'b1;
            if (CLEAR_ON_FLUSH) begin
                main_data_next = '0;
                skid_data_next = '0;
            end
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_xfer) begin
                        main_data_next = in_data;
                        state_next     = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_data_next = in_data;
                    end else if (out_xfer) begin
                        state_next = EMPTY;
                    end else if (in_xfer) begin
                        // Downstream stalled: park the new word and deassert ready for the next cycle.
                        skid_data_next = in_data;
                        in_ready_next  = 1'b0;
                        state_next     = TWO;
                    end
                end
                TWO: begin
                    if (out_ready) begin
                        main_data_next = skid_data_reg;
                        in_ready_next  = 1'b1;
                        state_next     = ONE;
                    end
                end
                default: begin
                    state_next    = EMPTY;
                    in_ready_next = 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_SKID_PERF_EN
    logic [CNT_W-1:0] stall_cycles_reg;

    // Counts stalls regardless of flush; saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_reg <= '0;
        end else if (main_valid && !out_ready && (stall_cycles_reg != {CNT_W{1'b1}})) begin
            stall_cycles_reg <= stall_cycles_reg + 1'b1;
        end
    end

    assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: scenario tasks plus a FIFO scoreboard monitor.
module tb_pipe_stage_skid;

    localparam int unsigned WIDTH          = 32;
    localparam bit          CLEAR_ON_FLUSH = 1'b1;
`ifdef PIPE_STAGE_SKID_PERF_EN
    localparam int unsigned CNT_W = 4;
`else
    localparam int unsigned CNT_W = 32;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
`ifdef PIPE_STAGE_SKID_PERF_EN
    logic [CNT_W-1:0] stall_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] exp_q[$];
    int               m_occ = 0;

    pipe_stage_skid #(
        .WIDTH(WIDTH),
        .CLEAR_ON_FLUSH(CLEAR_ON_FLUSH),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
`ifdef PIPE_STAGE_SKID_PERF_EN
        .occupancy(occupancy),
        .stall_cycles(stall_cycles)
`else
        .occupancy(occupancy)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard: inputs are stable at the falling edge, so transfers for the next rising edge are decided here.
    always @(negedge clk) begin
        logic             in_x, out_x;
        logic [WIDTH-1:0] exp_d;
        if (!rst) begin
            exp_q.delete();
            m_occ = 0;
        end else begin
            n_cmp++;
            if (in_ready !== (m_occ != 2)) begin
                n_err++;
                $display("FAIL sb_in_ready: got %b expected %b", in_ready, (m_occ != 2));
            end
            n_cmp++;
            if (occupancy !== 2'(m_occ)) begin
                n_err++;
                $display("FAIL sb_occupancy: got %0d expected %0d", occupancy, m_occ);
            end
            n_cmp++;
            if (out_valid !== (m_occ != 0)) begin
                n_err++;
                $display("FAIL sb_out_valid: got %b expected %b", out_valid, (m_occ != 0));
            end
            out_x = (m_occ != 0) && out_ready;
            in_x  = in_valid && (m_occ != 2);
            if (out_x) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected_output: got data 0x%0h expected no output", out_data);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (out_data !== exp_d) begin
                        n_err++;
                        $display("FAIL sb_out_data: got 0x%0h expected 0x%0h", out_data, exp_d);
                    end else begin
                        $display("xfer out data=0x%0h ok", out_data);
                    end
                end
            end
            if (flush) begin
                exp_q.delete();
                m_occ = 0;
            end else begin
                if (in_x) exp_q.push_back(in_data);
                case (m_occ)
                    0: m_occ = in_x ? 1 : 0;
                    1: m_occ = (in_x && !out_x) ? 2 : ((out_x && !in_x) ? 0 : 1);
                    default: m_occ = out_ready ? 1 : 2;
                endcase
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            flush     = 1'($urandom);
            in_valid  = 1'($urandom);
            in_data   = $urandom;
            out_ready = 1'($urandom);
            cyc();
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== '0) begin
                n_err++;
                $display("FAIL reset_state: got v=%b r=%b occ=%0d d=0x%0h expected v=0 r=1 occ=0 d=0",
                         out_valid, in_ready, occupancy, out_data);
            end
        end
        flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2 rst = 1'b1;
        cyc();
        $display("reset released");
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(i);
            cyc();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== WIDTH'(i) || occupancy !== 2'd1 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL stream_%0d: got v=%b d=0x%0h occ=%0d r=%b expected v=1 d=0x%0h occ=1 r=1",
                         i, out_valid, out_data, occupancy, in_ready, i);
            end
        end
        in_valid = 1'b0;
        cyc();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stream_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        cyc();
        out_ready = 1'b0;
        in_data   = 32'hB;
        cyc();
        n_cmp++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) begin
            n_err++;
            $display("FAIL bp_skid: got occ=%0d r=%b d=0x%0h expected occ=2 r=0 d=0xa", occupancy, in_ready, out_data);
        end
        in_data = 32'hC;
        cyc();
        n_cmp++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) begin
            n_err++;
            $display("FAIL bp_hold: got occ=%0d r=%b d=0x%0h expected occ=2 r=0 d=0xa", occupancy, in_ready, out_data);
        end
        out_ready = 1'b1;
        cyc();
        n_cmp++;
        if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== 32'hB) begin
            n_err++;
            $display("FAIL bp_release: got occ=%0d r=%b d=0x%0h expected occ=1 r=1 d=0xb", occupancy, in_ready, out_data);
        end
        cyc();
        n_cmp++;
        if (out_data !== 32'hC || occupancy !== 2'd1) begin
            n_err++;
            $display("FAIL bp_last: got d=0x%0h occ=%0d expected d=0xc occ=1", out_data, occupancy);
        end
        in_valid = 1'b0;
        cyc();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_flush();
        logic [WIDTH-1:0] exp_d;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        cyc();
        in_data = 32'h66;
        cyc();
        n_cmp++;
        if (occupancy !== 2'd2) begin
            n_err++;
            $display("FAIL flush_setup: got occ=%0d expected 2", occupancy);
        end
        flush   = 1'b1;
        in_data = 32'h77;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_d = CLEAR_ON_FLUSH ? '0 : WIDTH'(32'h55);
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 || out_data !== exp_d) begin
            n_err++;
            $display("FAIL flush_clear: got v=%b occ=%0d r=%b d=0x%0h expected v=0 occ=0 r=1 d=0x%0h",
                     out_valid, occupancy, in_ready, out_data, exp_d);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL flush_no_leak: got out_valid=%b d=0x%0h expected 0", out_valid, out_data);
            end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        cyc();
        in_data = 32'h22;
        cyc();
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 || out_data !== '0) begin
            n_err++;
            $display("FAIL async_reset: got v=%b occ=%0d r=%b d=0x%0h expected v=0 occ=0 r=1 d=0",
                     out_valid, occupancy, in_ready, out_data);
        end
        cyc();
        #2 rst = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h33;
        out_ready = 1'b1;
        cyc();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h33) begin
            n_err++;
            $display("FAIL async_resume: got v=%b d=0x%0h expected v=1 d=0x33", out_valid, out_data);
        end
        in_valid = 1'b0;
        cyc();
    endtask

`ifdef PIPE_STAGE_SKID_PERF_EN
    task automatic test_perf();
        int exp_c;
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (stall_cycles !== '0) begin
            n_err++;
            $display("FAIL perf_reset: got %0d expected 0", stall_cycles);
        end
        cyc();
        #2 rst = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h5;
        cyc();
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            exp_c = (i > 15) ? 15 : i;
            n_cmp++;
            if (stall_cycles !== CNT_W'(exp_c)) begin
                n_err++;
                $display("FAIL perf_count_%0d: got %0d expected %0d", i, stall_cycles, exp_c);
            end
        end
        out_ready = 1'b1;
        cyc();
        cyc();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
`ifdef PIPE_STAGE_SKID_PERF_EN
        test_perf();
`endif
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
